dice_roll_engine: RTL and testbench

- Sequential, parametrised successor to the combinational two-die adder.
- Rolls NUM_DICE dice of FACES faces each, from an internal LFSR or from externally supplied values (test mode).
- Produces the per-die values, their sum, a doubles flag and a saturating running game total, with a valid/ready output handshake.
- Sits between the game controller (start, mode) and the score/display logic.

---
 rtl/dice_roll_engine.sv | 166 ++++++++++++++++
 tb/tb_dice_roll_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/dice_roll_engine.sv
// Parametrised dice roller: NUM_DICE dice of FACES faces from an LFSR or an external bus,
// with per-die values, sum, doubles/err flags, a saturating running total and a valid/ready output.
module dice_roll_engine #(
  parameter int          NUM_DICE  = 2,
  parameter int          FACES     = 6,
  parameter int          DIE_W     = 3,
  parameter int          SUM_W     = 4,
  parameter int          TOT_W     = 8,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      mode_ext,
  input  logic [NUM_DICE*DIE_W-1:0] die_in,
  input  logic                      total_clr,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      out_valid,
  output logic [NUM_DICE*DIE_W-1:0] dice_out,
  output logic [SUM_W-1:0]          sum,
  output logic                      doubles,
  output logic                      err,
  output logic [TOT_W-1:0]          total,
  output logic                      overflow
);

  localparam int IDX_W = $clog2(NUM_DICE + 1);
  localparam int ACC_W = ((TOT_W > SUM_W) ? TOT_W : SUM_W) + 1;
  localparam logic [ACC_W-1:0] TOT_MAX = {{(ACC_W-TOT_W){1'b0}}, {TOT_W{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROLL = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                    state_r;
  logic [15:0]               lfsr_r;
  logic [IDX_W-1:0]          idx_r;
  logic                      mode_r;
  logic [NUM_DICE*DIE_W-1:0] ext_r;
  logic [NUM_DICE*DIE_W-1:0] dice_r;
  logic [SUM_W-1:0]          sum_r;
  logic                      doubles_r;
  logic                      err_r;
  logic [TOT_W-1:0]          total_r;
  logic                      overflow_r;
  logic                      busy_r;
  logic                      valid_r;

  logic [DIE_W-1:0]          ext_sel_s;
  logic [DIE_W-1:0]          cand_s;
  logic                      cand_ok_s;
  logic                      all_eq_s;
  logic [ACC_W-1:0]          acc_s;

  function automatic logic die_legal(input logic [DIE_W-1:0] v);
    return (v != {DIE_W{1'b0}}) && (v <= DIE_W'(FACES));
  endfunction

  // Select the candidate die for this cycle and evaluate the doubles/total arithmetic
  always_comb begin
    ext_sel_s = DIE_W'(ext_r >> (32'(idx_r) * DIE_W));
    if (mode_r) begin
      cand_s = ext_sel_s;
    end else begin
      cand_s = lfsr_r[DIE_W-1:0];
    end
    cand_ok_s = die_legal(cand_s);
    all_eq_s  = 1'b1;
    for (int i = 1; i < NUM_DICE; i++) begin
      all_eq_s = all_eq_s & (dice_r[i*DIE_W +: DIE_W] == dice_r[DIE_W-1:0]);
    end
    acc_s = ACC_W'(total_r) + ACC_W'(sum_r);
  end

  // Roll sequencer, LFSR and running total
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      lfsr_r     <= LFSR_SEED;
      idx_r      <= {IDX_W{1'b0}};
      mode_r     <= 1'b0;
      ext_r      <= {(NUM_DICE*DIE_W){1'b0}};
      dice_r     <= {(NUM_DICE*DIE_W){1'b0}};
      sum_r      <= {SUM_W{1'b0}};
      doubles_r  <= 1'b0;
      err_r      <= 1'b0;
      total_r    <= {TOT_W{1'b0}};
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
      valid_r    <= 1'b0;
    end else begin
      lfsr_r <= {lfsr_r[14:0], lfsr_r[15] ^ lfsr_r[13] ^ lfsr_r[12] ^ lfsr_r[10]};
      case (state_r)
        IDLE: begin
          if (start) begin
            mode_r    <= mode_ext;
            ext_r     <= die_in;
            sum_r     <= {SUM_W{1'b0}};
            err_r     <= 1'b0;
            doubles_r <= 1'b0;
            idx_r     <= {IDX_W{1'b0}};
            busy_r    <= 1'b1;
            state_r   <= ROLL;
          end
        end
        ROLL: begin
          if (idx_r == IDX_W'(NUM_DICE)) begin
            doubles_r <= all_eq_s;
            valid_r   <= 1'b1;
            state_r   <= DONE;
          end else if (mode_r || cand_ok_s) begin
            // External values are taken as-is; illegal ones only raise err
            for (int i = 0; i < NUM_DICE; i++) begin
              if (idx_r == IDX_W'(i)) begin
                dice_r[i*DIE_W +: DIE_W] <= cand_s;
              end
            end
            sum_r <= sum_r + SUM_W'(cand_s);
            idx_r <= idx_r + IDX_W'(1);
            if (!cand_ok_s) begin
              err_r <= 1'b1;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            valid_r <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase

      // Clear beats a coincident handshake, discarding that roll's sum
      if (total_clr) begin
        total_r    <= {TOT_W{1'b0}};
        overflow_r <= 1'b0;
      end else if ((state_r == DONE) && out_ready && !err_r) begin
        if (acc_s > TOT_MAX) begin
          total_r    <= {TOT_W{1'b1}};
          overflow_r <= 1'b1;
        end else begin
          total_r <= acc_s[TOT_W-1:0];
        end
      end
    end
  end

  assign busy      = busy_r;
  assign out_valid = valid_r;
  assign dice_out  = dice_r;
  assign sum       = sum_r;
  assign doubles   = doubles_r;
  assign err       = err_r;
  assign total     = total_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_dice_roll_engine.sv
// Directed self-checking bench for dice_roll_engine; a second instance with TOT_W=4
// shares all inputs and is checked only in the saturation section.
module tb_dice_roll_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       mode_ext = 1'b0;
  logic [5:0] die_in = 6'd0;
  logic       total_clr = 1'b0;
  logic       out_ready = 1'b0;

  logic       busy, out_valid, doubles, err, overflow;
  logic [5:0] dice_out;
  logic [3:0] sum;
  logic [7:0] total;

  logic       busy_b, out_valid_b, doubles_b, err_b, overflow_b;
  logic [5:0] dice_out_b;
  logic [3:0] sum_b;
  logic [3:0] total_b;

  int n_tests = 0;
  int n_fail  = 0;

  dice_roll_engine dut (
    .clk(clk), .rst(rst), .start(start), .mode_ext(mode_ext), .die_in(die_in),
    .total_clr(total_clr), .out_ready(out_ready), .busy(busy), .out_valid(out_valid),
    .dice_out(dice_out), .sum(sum), .doubles(doubles), .err(err), .total(total),
    .overflow(overflow)
  );

  dice_roll_engine #(.TOT_W(4)) dut_b (
    .clk(clk), .rst(rst), .start(start), .mode_ext(mode_ext), .die_in(die_in),
    .total_clr(total_clr), .out_ready(out_ready), .busy(busy_b), .out_valid(out_valid_b),
    .dice_out(dice_out_b), .sum(sum_b), .doubles(doubles_b), .err(err_b), .total(total_b),
    .overflow(overflow_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; total_clr = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("valid_seen", out_valid, 1);
  endtask

  // One external roll with out_ready held high; clr is pulsed on the handshake edge
  task automatic ext_roll(input logic [2:0] a, input logic [2:0] b, input logic clr,
                          input int e_sum, input int e_dbl, input int e_err, input int e_tot);
    int n;
    @(negedge clk);
    start = 1'b1; mode_ext = 1'b1; die_in = {b, a}; out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(n);
    chk("ext_latency", n, 3);
    chk("ext_dice", dice_out, {b, a});
    chk("ext_sum", sum, e_sum);
    chk("ext_doubles", doubles, e_dbl);
    chk("ext_err", err, e_err);
    total_clr = clr;
    @(posedge clk); #1;
    total_clr = 1'b0;
    chk("ext_valid_drop", out_valid, 0);
    chk("ext_total", total, e_tot);
  endtask

  initial begin
    int n;
    int tot;
    logic [5:0] seen;
    logic [5:0] d_hold;
    logic [3:0] s_hold;
    logic       dbl_hold;
    logic [2:0] d0, d1;

    // Reset state
    rst = 1'b1;
    #1;
    chk("rst_outs", {busy, out_valid, dice_out, sum, doubles, err, total, overflow}, 0);
    do_reset();

    ext_roll(3'd1, 3'd1, 1'b0, 2, 1, 0, 2);

    // Stalled roll: start and bus changes during ROLL/DONE must be ignored
    @(negedge clk);
    start = 1'b1; mode_ext = 1'b1; die_in = {3'd4, 3'd4}; out_ready = 1'b0;
    @(posedge clk); #1;
    die_in = {3'd1, 3'd2}; mode_ext = 1'b0;
    wait_valid(n);
    chk("stall_sum", sum, 8);
    repeat (2) begin
      @(posedge clk); #1;
      chk("stall_hold", {out_valid, dice_out, sum}, {1'b1, 6'o44, 4'd8});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("hs_start_ignored", {busy, out_valid}, 0);
    chk("stall_total", total, 10);

    do_reset();
    ext_roll(3'd6, 3'd5, 1'b0, 11, 0, 0, 11);
    ext_roll(3'd6, 3'd6, 1'b0, 12, 1, 0, 23);
    ext_roll(3'd0, 3'd7, 1'b0, 7, 0, 1, 23);
    ext_roll(3'd3, 3'd4, 1'b0, 7, 0, 0, 30);

    // Saturation on the 4-bit total instance
    do_reset();
    ext_roll(3'd6, 3'd6, 1'b0, 12, 1, 0, 12);
    chk("b_total_12", {overflow_b, total_b}, {1'b0, 4'd12});
    ext_roll(3'd6, 3'd6, 1'b0, 12, 1, 0, 24);
    chk("b_total_sat", {overflow_b, total_b}, {1'b1, 4'd15});
    chk("a_no_ovf", overflow, 0);
    @(negedge clk); total_clr = 1'b1;
    @(negedge clk); total_clr = 1'b0;
    chk("b_clr", {overflow_b, total_b}, 0);
    chk("a_clr", total, 0);
    ext_roll(3'd2, 3'd2, 1'b1, 4, 1, 0, 0);

    // LFSR rolls with random consumer stalls
    do_reset();
    tot = 0;
    seen = 6'd0;
    for (int r = 0; r < 1000; r++) begin
      @(negedge clk);
      start = 1'b1; mode_ext = 1'b0; out_ready = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      wait_valid(n);
      d_hold = dice_out; s_hold = sum; dbl_hold = doubles;
      d0 = d_hold[2:0]; d1 = d_hold[5:3];
      chk("lfsr_range0", (d0 >= 3'd1) && (d0 <= 3'd6), 1);
      chk("lfsr_range1", (d1 >= 3'd1) && (d1 <= 3'd6), 1);
      chk("lfsr_sum", s_hold, 4'(d0) + 4'(d1));
      chk("lfsr_doubles", dbl_hold, d0 == d1);
      chk("lfsr_err", err, 0);
      if (d0 >= 3'd1 && d0 <= 3'd6) seen[d0-3'd1] = 1'b1;
      if (d1 >= 3'd1 && d1 <= 3'd6) seen[d1-3'd1] = 1'b1;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
        chk("lfsr_stable", {out_valid, dice_out, sum, doubles}, {1'b1, d_hold, s_hold, dbl_hold});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      tot = tot + int'(s_hold);
      if (tot > 255) tot = 255;
      chk("lfsr_total", total, tot);
    end
    chk("faces_seen", seen, 6'b111111);

    // Reset during ROLL
    @(negedge clk);
    start = 1'b1; mode_ext = 1'b1; die_in = {3'd3, 3'd2}; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("roll_busy", busy, 1);
    rst = 1'b1;
    #1;
    chk("rst_roll_outs", {busy, out_valid, dice_out, sum, doubles, err, total, overflow}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_roll_idle", {busy, out_valid}, 0);

    // Reset during DONE with the consumer stalled
    @(negedge clk);
    start = 1'b1; mode_ext = 1'b1; die_in = {3'd5, 3'd5}; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    wait_valid(n);
    rst = 1'b1;
    #1;
    chk("rst_done_outs", {busy, out_valid, dice_out, sum, doubles, err, total, overflow}, 0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_done_idle", {busy, out_valid}, 0);

    ext_roll(3'd2, 3'd3, 1'b0, 5, 0, 0, 5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
